// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  typedef logic [7:0] w8;
  typedef logic [7:0] r8;

  // Boot loader handshake bytes.
  localparam w8 BOOT_REQ_BYTE = 8'h99;
  localparam w8 BOOT_ACK_BYTE = 8'haa;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    WAIT = 2'd2
  } tx_arb_state_t;

  // Which requester owns the byte currently in flight.
  typedef enum logic {
    GRANT_CPU  = 1'b0,
    GRANT_BOOT = 1'b1
  } tx_grant_t;

endpackage

// File: rtl/uart_tx_arbiter_fifo.sv
// Byte FIFO buffering CPU output bytes; full flag is registered, storage is not reset.
module byte_fifo
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  w8                        push_data,
  input  logic                     pop,
  output w8                        head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  w8             mem [DEPTH];
  logic [AW-1:0] rd_ptr_p1;
  logic [AW-1:0] wr_ptr_p1;
  logic [CW-1:0] count_p1;
  logic [CW-1:0] count_next;
  logic          full_p1;
  logic          do_push;
  logic          do_pop;

  // A push is refused while full, so a pop always wins on a full FIFO.
  assign do_push = push & ~full_p1;
  assign do_pop  = pop & (count_p1 != '0);

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count_p1;
    case ({do_push, do_pop})
      2'b10:   count_next = count_p1 + CNT_ONE;
      2'b01:   count_next = count_p1 - CNT_ONE;
      default: count_next = count_p1;
    endcase
  end

  // Pointer, count and full-flag registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_p1 <= '0;
      wr_ptr_p1 <= '0;
      count_p1  <= '0;
      full_p1   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_p1 <= wr_ptr_p1 + PTR_ONE;
      if (do_pop)  rd_ptr_p1 <= rd_ptr_p1 + PTR_ONE;
      count_p1 <= count_next;
      full_p1  <= (count_next == CNT_FULL);
    end
  end

  // Byte storage.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_p1] <= push_data;
  end

  assign head_data = mem[rd_ptr_p1];
  assign full      = full_p1;
  assign empty     = (count_p1 == '0);
  assign count     = count_p1;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates the single UART sender between the boot loader (one-entry hold)
// and the CPU byte FIFO, sequencing the sender's tx_start/tx_busy handshake.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int START_GAP  = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          boot_start,
  input  w8                             boot_data,
  output logic                          boot_busy,
  input  logic                          cpu_valid,
  input  w8                             cpu_data,
  output logic                          cpu_ready,
  input  logic                          tx_busy,
  output logic                          tx_start,
  output w8                             sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int GW = (START_GAP > 1) ? $clog2(START_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(START_GAP - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  tx_arb_state_t state_p1, state_next;
  tx_grant_t     grant_p1, grant_next;
  logic [GW-1:0] gap_cnt_p1, gap_cnt_next;
  logic          hold_full_p1;
  w8             hold_data_p1;
  logic          tx_start_p1;
  w8             sdata_p1;
  logic          issue;
  logic          issue_boot;
  w8             issue_data;
  w8             fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          hold_capture;

  assign hold_capture = boot_start & ~hold_full_p1;
  assign fifo_pop     = issue & ~issue_boot;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (cpu_valid),
    .push_data (cpu_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state and issue decision; boot hold outranks the FIFO head.
  always_comb begin
    state_next   = state_p1;
    grant_next   = grant_p1;
    gap_cnt_next = gap_cnt_p1;
    issue        = 1'b0;
    issue_boot   = 1'b0;
    issue_data   = sdata_p1;
    case (state_p1)
      IDLE: begin
        if (!tx_busy && (hold_full_p1 || !fifo_empty)) begin
          issue        = 1'b1;
          issue_boot   = hold_full_p1;
          grant_next   = hold_full_p1 ? GRANT_BOOT : GRANT_CPU;
          issue_data   = hold_full_p1 ? hold_data_p1 : fifo_head;
          gap_cnt_next = '0;
          state_next   = GAP;
        end
      end
      GAP: begin
        // Sender has not yet raised tx_busy here, so it is not looked at.
        if (gap_cnt_p1 == GAP_LAST) state_next = WAIT;
        else                        gap_cnt_next = gap_cnt_p1 + GAP_ONE;
      end
      WAIT: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control registers: FSM, grant owner, gap counter, hold flag, sender outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_p1     <= IDLE;
      grant_p1     <= GRANT_CPU;
      gap_cnt_p1   <= '0;
      hold_full_p1 <= 1'b0;
      tx_start_p1  <= 1'b0;
      sdata_p1     <= '0;
    end else begin
      state_p1    <= state_next;
      grant_p1    <= grant_next;
      gap_cnt_p1  <= gap_cnt_next;
      tx_start_p1 <= issue;
      if (issue) sdata_p1 <= issue_data;
      if (issue_boot)        hold_full_p1 <= 1'b0;
      else if (hold_capture) hold_full_p1 <= 1'b1;
    end
  end

  // Boot byte storage, loaded only when the hold is empty.
  always_ff @(posedge clock) begin
    if (hold_capture) hold_data_p1 <= boot_data;
  end

  assign tx_start  = tx_start_p1;
  assign sdata     = sdata_p1;
  assign cpu_ready = ~fifo_full;
  assign boot_busy = hold_full_p1 | ((state_p1 != IDLE) && (grant_p1 == GRANT_BOOT));

endmodule
